display_scan_controller: RTL and testbench
==========================================

// Module: display_scan_controller
// PURPOSE
//  Scan scheduler for the NUM_DIGITS-digit common-anode 7-seg display.
//  Time-shares the single segment decoder between the digits.
//  Per digit slot: an anti-ghosting blanking interval, then a PWM on-window set by brightness.
//  Sits between the decade-counter BCD bus and the digit decoder / digit-select pins.
// PARAMETERS
//  NUM_DIGITS    4      digits scanned, left to right
//  SLOT_CYCLES   16384  clk_in cycles per digit slot (>= BLANK_CYCLES + 2^BRIGHT_W)
//  BLANK_CYCLES  64     cycles at slot start with all digits off
//  BRIGHT_W      4      brightness width; ON_STEP = (SLOT_CYCLES-BLANK_CYCLES) >> BRIGHT_W
// PORTS
//  clk_in        in   1             system clock
//  rst_n_in      in   1             reset, asynchronous, active-low
//  enable        in   1             1 = scan; 0 = display dark, scan position held at frame start
//  brightness    in   BRIGHT_W      on-window = brightness*ON_STEP cycles; 0 = dark
//  bcd_digits    in   4*NUM_DIGITS  packed BCD; [4*NUM_DIGITS-1 -: 4] = leftmost digit
//  digit_select  out  NUM_DIGITS    active-low one-cold; bit NUM_DIGITS-1 = leftmost
//  digit_value   out  4             BCD of current slot's digit, to decoder
//  digit_index   out  clog2(NUM_DIGITS)  current slot, 0 = leftmost
//  frame_done    out  1             1-cycle pulse on last cycle of last slot
// BEHAVIOUR
//  - Reset (async, rst_n_in=0):
//    - outputs: digit_select all 1s, digit_value 0, digit_index 0, frame_done 0.
//    - internal: slot_cnt 0, latches cleared.
//  - Counters: slot_cnt runs 0..SLOT_CYCLES-1, then wraps to 0 and digit_index increments.
//    - digit_index wraps NUM_DIGITS-1 -> 0.
//  - FSM: IDLE -> BLANK -> ON -> OFF -> BLANK (next slot).
//    - IDLE: enable=0.
//    - BLANK: slot_cnt < BLANK_CYCLES.
//    - ON: BLANK_CYCLES <= slot_cnt < BLANK_CYCLES+on_len.
//    - OFF: remainder of slot.
//    - ON is skipped when on_len=0.
//  - All outputs are registered. In the cycle where slot_cnt=c:
//    - digit_select shows slot c's state.
//    - The selected bit is 0 only in ON; every other bit is always 1.
//  - Brightness is latched at slot start (slot_cnt=0): on_len = brightness_latched*ON_STEP.
//    - A mid-slot change takes effect next slot.
//  - bcd_digits is latched as a whole at frame start (digit_index=0, slot_cnt=0), giving a tear-free frame.
//    - A mid-frame change is shown from the next frame.
//  - digit_value = latched digit[digit_index], updated at slot start.
//    - Stays valid through the BLANK, ON and OFF states.
//  - frame_done = 1 exactly when digit_index=NUM_DIGITS-1 and slot_cnt=SLOT_CYCLES-1.
//    - Pulses even when brightness=0.
//  - enable 1->0: next cycle FSM=IDLE; digit_select all 1s; slot_cnt=0; digit_index=0; frame_done 0.
//  - enable 0->1: scan starts at digit 0, slot_cnt 0; BCD and brightness re-latched that cycle.
//  - Never more than one digit driven; no digit is driven during the first BLANK_CYCLES of any slot.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//   - Digits equal to 0 left of the first nonzero latched digit keep their select bit 1 in ON.
//   - The rightmost digit is always shown, so 0000 shows a single "0".
//   - Timing and frame_done are unchanged.
//  LEADING_ZERO_BLANK_EN undefined: every digit is shown, including leading zeros.
// TESTING (SLOT_CYCLES=32, BLANK_CYCLES=4, BRIGHT_W=2 -> ON_STEP=7, frame=128 cycles)
//  1. Reset:
//     - stimulus: rst_n_in=0 asserted mid-ON.
//     - response: same cycle (async) digit_select=1111, digit_value=0, digit_index=0, frame_done=0.
//  2. Basic scan:
//     - stimulus: enable=1, brightness=3, bcd=16'h1234.
//     - response, slot 0: c0-3 select=1111; c4-24 select=0111, value=1; c25-31 select=1111.
//     - slots 1..3: select 1011/1101/1110, value 2/3/4.
//     - frame_done at cycle 127 only.
//  3. brightness=0:
//     - response: digit_select=1111 for the whole frame; frame_done still pulses every 128 cycles.
//     - brightness 0->2 at cycle 40 -> slot 1 stays dark; slot 2 on for 14 cycles (c4-17).
//  4. Tear-free update:
//     - stimulus: bcd 1234->5678 at cycle 40.
//     - response: values 1,2,3,4 to end of frame; next frame 5,6,7,8.
//  5. Enable drop:
//     - stimulus: enable=0 at cycle 10 of slot 2.
//     - response: next cycle 1111, index 0.
//     - re-enable -> slot 0 restarts at c0 with blanking.
//  6. LEADING_ZERO_BLANK_EN, bcd=16'h0040:
//     - response: slots 0,1 dark; slot 2 shows 4; slot 3 shows 0.
//     - bcd=16'h0000 -> only slot 3 lit, value 0.
//     - without macro, all four slots lit.

Source files
------------

// File: rtl/display_scan_controller.sv
// Multiplexed 7-seg scan scheduler: per-digit blanking, PWM on-window, tear-free BCD frame latch.
// Optional LEADING_ZERO_BLANK_EN keeps leading zero digits dark (rightmost digit always shown).
module display_scan_controller #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SLOT_CYCLES  = 16384,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned BRIGHT_W     = 4
) (
  input  logic                                          clk_in,
  input  logic                                          rst_n_in,
  input  logic                                          enable,
  input  logic [BRIGHT_W-1:0]                           brightness,
  input  logic [4*NUM_DIGITS-1:0]                       bcd_digits,
  output logic [NUM_DIGITS-1:0]                         digit_select,
  output logic [3:0]                                    digit_value,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_index,
  output logic                                          frame_done
);

  localparam int unsigned CNT_W   = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned END_W   = CNT_W + 1;
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned ON_STEP = (SLOT_CYCLES - BLANK_CYCLES) >> BRIGHT_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_ON    = 2'd2;
  localparam logic [1:0] S_OFF   = 2'd3;

  logic [1:0]              state, state_nxt;
  logic [CNT_W-1:0]        slot_cnt, cnt_nxt;
  logic [IDX_W-1:0]        idx_nxt;
  logic                    load_slot, load_frame;
  logic [BRIGHT_W-1:0]     bright_lat, cur_bright;
  logic [4*NUM_DIGITS-1:0] bcd_lat, cur_bcd;
  logic [END_W-1:0]        on_end;
  logic [3:0]              cur_digit;
  logic [NUM_DIGITS-1:0]   sel_nxt;
  logic                    frame_done_nxt;
  logic                    digit_lit;
`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    leading;
`endif

  // Next-state/position; outputs are precomputed for the upcoming cycle so they line up with slot_cnt.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = slot_cnt;
    idx_nxt        = digit_index;
    load_slot      = 1'b0;
    load_frame     = 1'b0;
    cur_bright     = bright_lat;
    cur_bcd        = bcd_lat;
    on_end         = '0;
    cur_digit      = '0;
    sel_nxt        = '1;
    frame_done_nxt = 1'b0;
    digit_lit      = 1'b1;

    if (!enable) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else if (state == S_IDLE) begin
      cnt_nxt    = '0;
      idx_nxt    = '0;
      load_slot  = 1'b1;
      load_frame = 1'b1;
    end else if (slot_cnt == CNT_W'(SLOT_CYCLES - 1)) begin
      cnt_nxt    = '0;
      idx_nxt    = (digit_index == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_index + IDX_W'(1);
      load_slot  = 1'b1;
      load_frame = (idx_nxt == '0);
    end else begin
      cnt_nxt = slot_cnt + CNT_W'(1);
    end

    if (load_slot)  cur_bright = brightness;
    if (load_frame) cur_bcd    = bcd_digits;
    on_end = END_W'(BLANK_CYCLES) + END_W'(cur_bright) * END_W'(ON_STEP);

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) cur_digit = cur_bcd[4*(NUM_DIGITS-1-i) +: 4];
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank while every digit from the left up to and including it is zero.
    leading  = 1'b1;
    lz_blank = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cur_bcd[4*(NUM_DIGITS-1-i) +: 4] != 4'd0) leading = 1'b0;
      lz_blank[i] = leading && (i != NUM_DIGITS - 1);
      if (idx_nxt == IDX_W'(i)) digit_lit = !lz_blank[i];
    end
`endif

    if (enable) begin
      if (cnt_nxt < CNT_W'(BLANK_CYCLES))  state_nxt = S_BLANK;
      else if ({1'b0, cnt_nxt} < on_end)   state_nxt = S_ON;
      else                                 state_nxt = S_OFF;
    end

    if (state_nxt == S_ON && digit_lit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_nxt == IDX_W'(i)) sel_nxt[NUM_DIGITS-1-i] = 1'b0;
      end
    end

    frame_done_nxt = (state_nxt != S_IDLE) && (idx_nxt == IDX_W'(NUM_DIGITS - 1)) &&
                     (cnt_nxt == CNT_W'(SLOT_CYCLES - 1));
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= S_IDLE;
      slot_cnt     <= '0;
      digit_index  <= '0;
      bright_lat   <= '0;
      bcd_lat      <= '0;
      digit_select <= '1;
      digit_value  <= '0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_nxt;
      slot_cnt     <= cnt_nxt;
      digit_index  <= idx_nxt;
      if (load_slot)  bright_lat  <= brightness;
      if (load_frame) bcd_lat     <= bcd_digits;
      if (load_slot)  digit_value <= cur_digit;
      digit_select <= sel_nxt;
      frame_done   <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with a short slot (32 cycles, 4 blank, ON_STEP 7).
module tb_display_scan_controller;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        enable;
  logic [1:0]  brightness;
  logic [15:0] bcd_digits;
  logic [3:0]  digit_select;
  logic [3:0]  digit_value;
  logic [1:0]  digit_index;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  display_scan_controller #(
    .NUM_DIGITS(4), .SLOT_CYCLES(32), .BLANK_CYCLES(4), .BRIGHT_W(2)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .enable(enable), .brightness(brightness),
    .bcd_digits(bcd_digits), .digit_select(digit_select), .digit_value(digit_value),
    .digit_index(digit_index), .frame_done(frame_done)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Walk ncyc cycles of one slot; at cycle chg_c the inputs switch after that cycle is checked.
  task automatic run_slot(input int idx, input int val, input int on_len, input int ncyc,
                          input int chg_c, input logic [1:0] nb, input logic [15:0] nbcd,
                          input logic nen);
    logic [3:0] exp_sel;
    for (int c = 0; c < ncyc; c++) begin
      exp_sel = 4'hF;
      if (c >= 4 && c < 4 + on_len) exp_sel[3-idx] = 1'b0;
      check_eq($sformatf("s%0d c%0d sel", idx, c), 32'(digit_select), 32'(exp_sel));
      check_eq($sformatf("s%0d c%0d val", idx, c), 32'(digit_value), 32'(val));
      check_eq($sformatf("s%0d c%0d idx", idx, c), 32'(digit_index), 32'(idx));
      check_eq($sformatf("s%0d c%0d fd", idx, c), 32'(frame_done), 32'(idx == 3 && c == 31));
      if (c == chg_c) begin
        brightness = nb;
        bcd_digits = nbcd;
        enable     = nen;
      end
      @(posedge clk_in);
      #1;
    end
  endtask

  initial begin
    rst_n_in   = 1'b1;
    enable     = 1'b0;
    brightness = 2'd3;
    bcd_digits = 16'h1234;
    #1 rst_n_in = 1'b0;
    #2;
    check_eq("rst0 sel", 32'(digit_select), 32'hF);
    check_eq("rst0 val", 32'(digit_value), 32'h0);
    check_eq("rst0 idx", 32'(digit_index), 32'h0);
    check_eq("rst0 fd", 32'(frame_done), 32'h0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    enable   = 1'b1;
    @(posedge clk_in);
    #1;

    // Basic scan; bcd changes mid-frame (tear-free), brightness drops to 0 mid-slot 3
    run_slot(0, 1, 21, 32, -1, 2'd3, 16'h1234, 1'b1);
    run_slot(1, 2, 21, 32, 8, 2'd3, 16'h5678, 1'b1);
    run_slot(2, 3, 21, 32, -1, 2'd3, 16'h5678, 1'b1);
    run_slot(3, 4, 21, 32, 10, 2'd0, 16'h5678, 1'b1);

    // Dark frame; brightness 0->2 at cycle 40 lights slots 2,3 only
    run_slot(0, 5, 0, 32, -1, 2'd0, 16'h5678, 1'b1);
    run_slot(1, 6, 0, 32, 8, 2'd2, 16'h5678, 1'b1);
    run_slot(2, 7, 14, 32, -1, 2'd2, 16'h5678, 1'b1);
    run_slot(3, 8, 14, 32, -1, 2'd2, 16'h5678, 1'b1);

    // Enable drop at cycle 10 of slot 2 (inside the on-window)
    run_slot(0, 5, 14, 32, -1, 2'd2, 16'h5678, 1'b1);
    run_slot(1, 6, 14, 32, -1, 2'd2, 16'h5678, 1'b1);
    run_slot(2, 7, 14, 11, 10, 2'd2, 16'h5678, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("idle%0d sel", k), 32'(digit_select), 32'hF);
      check_eq($sformatf("idle%0d idx", k), 32'(digit_index), 32'h0);
      check_eq($sformatf("idle%0d fd", k), 32'(frame_done), 32'h0);
      @(posedge clk_in);
      #1;
    end

    // Re-enable with 0040: leading-zero handling
    enable     = 1'b1;
    brightness = 2'd1;
    bcd_digits = 16'h0040;
    @(posedge clk_in);
    #1;
    run_slot(0, 0, LZ ? 0 : 7, 32, -1, 2'd1, 16'h0040, 1'b1);
    run_slot(1, 0, LZ ? 0 : 7, 32, -1, 2'd1, 16'h0040, 1'b1);
    run_slot(2, 4, 7, 32, -1, 2'd1, 16'h0040, 1'b1);
    run_slot(3, 0, 7, 32, 10, 2'd1, 16'h0000, 1'b1);

    // All-zero frame: only the rightmost digit lit when blanking is enabled
    run_slot(0, 0, LZ ? 0 : 7, 32, -1, 2'd1, 16'h0000, 1'b1);
    run_slot(1, 0, LZ ? 0 : 7, 32, -1, 2'd1, 16'h0000, 1'b1);
    run_slot(2, 0, LZ ? 0 : 7, 32, -1, 2'd1, 16'h0000, 1'b1);
    run_slot(3, 0, 7, 32, 10, 2'd1, 16'h1234, 1'b1);

    // Async reset in the middle of the on-window
    run_slot(0, 1, 7, 6, -1, 2'd1, 16'h1234, 1'b1);
    check_eq("preRst sel", 32'(digit_select), 32'h7);
    check_eq("preRst val", 32'(digit_value), 32'h1);
    #2 rst_n_in = 1'b0;
    #1;
    check_eq("rst1 sel", 32'(digit_select), 32'hF);
    check_eq("rst1 val", 32'(digit_value), 32'h0);
    check_eq("rst1 idx", 32'(digit_index), 32'h0);
    check_eq("rst1 fd", 32'(frame_done), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
